instr_fetch_dispatch: RTL and testbench

- Front-end controller of the bus-based microcontroller. Owns the program counter (PC) and fetches 16-bit instruction words from program memory through a req/ack handshake.
- Holds each instruction on the instruction register bus, which feeds the opcode-decoding execution FSMs (ALU, ALU-immediate, load/store, branch), and waits for their `done` pulse.
- Between instructions it inserts a one-cycle NOP bubble so every execution FSM returns to its idle state before the next word is presented.

---
 rtl/instr_fetch_dispatch.sv | 223 ++++++++++++++++++++++
 tb/tb_instr_fetch_dispatch.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_dispatch.sv
// -----------------------------------------------------------------------------
// instr_fetch_dispatch
//
// Front end of the bus-based microcontroller. Owns the program counter and
// fetches 16-bit instruction words over a req/ack handshake. Each word is
// presented on ir_o to the execution FSMs until they pulse exec_done_i. A
// one-cycle all-zero bubble between instructions lets every execution FSM
// return to idle before the next word appears.
//
// Optional build macro: WATCHDOG_EN. When defined, an EXEC-cycle counter
// halts the core with wdt_err_o if exec_done_i has not arrived within
// TIMEOUT cycles. When undefined, EXEC waits indefinitely and wdt_err_o is 0.
//
// Ports:
//   clk              system clock, all state on rising edge
//   rst              asynchronous, active-high reset
//   mem_addr_o       fetch address (always equals pc_o)
//   mem_req_o        fetch request, high for the whole FETCH state
//   mem_ack_i        memory ack; mem_rdata_i valid in the same cycle
//   mem_rdata_i      fetched instruction word
//   ir_o             instruction bus to the execution FSMs
//   pc_o             current program counter
//   pc_inc_i         PC increment strobe (honoured in EXEC only)
//   pc_load_i        branch load strobe (honoured in EXEC only, beats pc_inc_i)
//   pc_load_val_i    branch target
//   exec_done_i      execution complete (honoured in EXEC only)
//   halted_o         core stopped
//   illegal_o        sticky illegal-opcode flag
//   wdt_err_o        sticky watchdog flag
//
// States:
//   RESET_BUBBLE | ir = 0 for one cycle after reset
//   FETCH        | mem_req high until mem_ack, word captured in hold register
//   DECODE       | classify captured word: illegal / HALT / NOP / execute
//   EXEC         | ir held, PC strobes applied, wait for exec_done
//   BUBBLE       | ir = 0 for one cycle between instructions
//   HALT         | absorbing until reset
// -----------------------------------------------------------------------------
module instr_fetch_dispatch #(
    parameter int          ADDR_W     = 8,
    parameter logic [15:0] LEGAL_MASK = 16'h8007,
    parameter int          TIMEOUT    = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_req_o,
    input  logic              mem_ack_i,
    input  logic [15:0]       mem_rdata_i,
    output logic [15:0]       ir_o,
    output logic [ADDR_W-1:0] pc_o,
    input  logic              pc_inc_i,
    input  logic              pc_load_i,
    input  logic [ADDR_W-1:0] pc_load_val_i,
    input  logic              exec_done_i,
    output logic              halted_o,
    output logic              illegal_o,
    output logic              wdt_err_o
);

    typedef enum logic [2:0] {
        S_RESET_BUBBLE = 3'd0,
        S_FETCH        = 3'd1,
        S_DECODE       = 3'd2,
        S_EXEC         = 3'd3,
        S_BUBBLE       = 3'd4,
        S_HALT         = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic [15:0]       hold_q, hold_d;
    logic              illegal_q, illegal_d;

    logic [3:0]        dec_op;
    logic              dec_legal;
    logic              wdt_fire;

    assign dec_op    = hold_q[15:12];
    assign dec_legal = LEGAL_MASK[dec_op];

`ifdef WATCHDOG_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wdt_cnt_q, wdt_cnt_d;
    logic             wdt_err_q, wdt_err_d;

    // Counter reads k-1 in the k-th EXEC cycle, so the TIMEOUT-th cycle is the
    // last one; exec_done in that same cycle still takes precedence.
    always_comb begin
        wdt_cnt_d = '0;
        if (state_q == S_EXEC) begin
            wdt_cnt_d = wdt_cnt_q + CNT_W'(1);
        end
    end

    assign wdt_fire  = (state_q == S_EXEC) && !exec_done_i &&
                       (wdt_cnt_q == CNT_W'(TIMEOUT - 1));
    assign wdt_err_d = wdt_err_q | wdt_fire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdt_cnt_q <= '0;
            wdt_err_q <= 1'b0;
        end else begin
            wdt_cnt_q <= wdt_cnt_d;
            wdt_err_q <= wdt_err_d;
        end
    end

    assign wdt_err_o = wdt_err_q;
`else
    assign wdt_fire  = 1'b0;
    assign wdt_err_o = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RESET_BUBBLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET_BUBBLE: state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ack_i) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!dec_legal) begin
                    state_d = S_HALT;
                end else if (dec_op == 4'hF) begin
                    state_d = S_HALT;
                end else if (dec_op == 4'h0) begin
                    state_d = S_BUBBLE;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (exec_done_i) begin
                    state_d = S_BUBBLE;
                end else if (wdt_fire) begin
                    state_d = S_HALT;
                end
            end
            S_BUBBLE: state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_HALT;
        endcase
    end

    // FSM outputs
    always_comb begin
        mem_req_o = (state_q == S_FETCH);
        halted_o  = (state_q == S_HALT);
    end

    // Datapath next values
    always_comb begin
        hold_d    = hold_q;
        pc_d      = pc_q;
        ir_d      = 16'h0000;
        illegal_d = illegal_q;

        if (state_q == S_FETCH && mem_ack_i) begin
            hold_d = mem_rdata_i;
        end

        if (state_q == S_DECODE) begin
            if (!dec_legal) begin
                illegal_d = 1'b1;
            end else if (dec_op == 4'h0) begin
                pc_d = pc_q + ADDR_W'(1);
            end
        end

        if (state_q == S_EXEC) begin
            if (pc_load_i) begin
                pc_d = pc_load_val_i;
            end else if (pc_inc_i) begin
                pc_d = pc_q + ADDR_W'(1);
            end
        end

        // ir is non-zero only while staying in (or entering) EXEC
        if (state_d == S_EXEC) begin
            if (state_q == S_DECODE) begin
                ir_d = hold_q;
            end else begin
                ir_d = ir_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= '0;
            ir_q      <= 16'h0000;
            hold_q    <= 16'h0000;
            illegal_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            hold_q    <= hold_d;
            illegal_q <= illegal_d;
        end
    end

    assign mem_addr_o = pc_q;
    assign pc_o       = pc_q;
    assign ir_o       = ir_q;
    assign illegal_o  = illegal_q;

endmodule

// File: tb/tb_instr_fetch_dispatch.sv
module tb_instr_fetch_dispatch;

    localparam logic [15:0] MASK  = 16'h8007;
    localparam int          WDT_T = 32;
`ifdef WATCHDOG_EN
    localparam int LONG_DONE = 20;
`else
    localparam int LONG_DONE = 45;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  mem_addr;
    logic        mem_req;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = 16'h0000;
    logic [15:0] ir;
    logic [7:0]  pc;
    logic        pc_inc = 1'b0;
    logic        pc_load = 1'b0;
    logic [7:0]  pc_load_val = 8'h00;
    logic        exec_done = 1'b0;
    logic        halted;
    logic        illegal;
    logic        wdt_err;

    instr_fetch_dispatch #(
        .ADDR_W    (8),
        .LEGAL_MASK(16'h8007),
        .TIMEOUT   (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_addr_o   (mem_addr),
        .mem_req_o    (mem_req),
        .mem_ack_i    (mem_ack),
        .mem_rdata_i  (mem_rdata),
        .ir_o         (ir),
        .pc_o         (pc),
        .pc_inc_i     (pc_inc),
        .pc_load_i    (pc_load),
        .pc_load_val_i(pc_load_val),
        .exec_done_i  (exec_done),
        .halted_o     (halted),
        .illegal_o    (illegal),
        .wdt_err_o    (wdt_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // instruction-level reference state
    logic [7:0] m_pc;
    logic       m_halted, m_illegal, m_wdt;

    typedef struct packed {
        logic [15:0] word;
        int          dly;
        int          inc_at;
        int          load_at;
        logic [7:0]  lval;
        int          done_at;
        int          rst_at;
        logic [7:0]  exp_pc;
        logic        exp_h;
        logic        exp_i;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_pc      = 8'h00;
        m_halted  = 1'b0;
        m_illegal = 1'b0;
        m_wdt     = 1'b0;
    endtask

    // Assert reset mid-cycle; outputs must clear without waiting for a clock.
    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_pc", pc, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_ir", ir, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_halted", halted, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_wdt", wdt_err, 0);
        pc_inc = 1'b0; pc_load = 1'b0; exec_done = 1'b0; mem_ack = 1'b0;
        step();
        step();
        rst = 1'b0;
        model_reset();
    endtask

    // One instruction, from waiting for the fetch request through to the next
    // FETCH (or HALT). Strobe indices are 1-based EXEC cycles, 0 = never.
    // done_at = 0 means no exec_done at all (watchdog case).
    task automatic do_instr(input logic [15:0] word, input int ack_delay, input int inc_at,
                            input int load_at, input logic [7:0] load_val,
                            input int done_at, input int rst_at);
        int w;
        int n;
        logic [3:0] op;
        logic [15:0] mask_v;
        mask_v = MASK;
        op = word[15:12];
        w = 0;
        while (mem_req !== 1'b1 && w < 10) begin
            step();
            w++;
        end
        chk("req_seen", mem_req, 1);
        if (mem_req !== 1'b1) return;
        chk("fetch_addr", mem_addr, m_pc);
        for (int d = 0; d <= ack_delay; d++) begin
            chk("req_held", mem_req, 1);
            chk("ir_fetch", ir, 0);
            mem_ack   = (d == ack_delay);
            mem_rdata = (d == ack_delay) ? word : 16'($urandom);
            step();
        end
        mem_ack   = 1'b0;
        mem_rdata = 16'($urandom);
        chk("req_drop", mem_req, 0);
        chk("ir_decode", ir, 0);
        chk("pc_decode", pc, m_pc);
        step();
        if (!mask_v[op]) begin
            m_illegal = 1'b1;
            m_halted  = 1'b1;
        end else if (op == 4'hF) begin
            m_halted = 1'b1;
        end else if (op == 4'h0) begin
            m_pc = m_pc + 8'd1;
            chk("nop_ir", ir, 0);
            chk("nop_pc", pc, m_pc);
            step();
        end else begin
            n = (done_at == 0) ? WDT_T : done_at;
            for (int e = 1; e <= n; e++) begin
                if (e == rst_at) begin
                    async_reset();
                    return;
                end
                chk("exec_ir", ir, word);
                chk("exec_halted", halted, 0);
                chk("exec_req", mem_req, 0);
                pc_inc      = (e == inc_at);
                pc_load     = (e == load_at);
                pc_load_val = (e == load_at) ? load_val : 8'($urandom);
                exec_done   = (e == done_at);
                step();
                if (e == load_at) m_pc = load_val;
                else if (e == inc_at) m_pc = m_pc + 8'd1;
            end
            pc_inc = 1'b0; pc_load = 1'b0; exec_done = 1'b0;
            if (done_at == 0) begin
                m_halted = 1'b1;
                m_wdt    = 1'b1;
            end else begin
                chk("bubble_ir", ir, 0);
                chk("bubble_pc", pc, m_pc);
                chk("bubble_req", mem_req, 0);
                step();
            end
        end
        chk("halted", halted, m_halted);
        chk("illegal", illegal, m_illegal);
        chk("wdt_err", wdt_err, m_wdt);
        if (m_halted) begin
            chk("halt_ir", ir, 0);
            chk("halt_pc", pc, m_pc);
            chk("halt_req", mem_req, 0);
        end
    endtask

    // HALT must ignore every strobe and never request memory again.
    task automatic halt_idle();
        for (int i = 0; i < 20; i++) begin
            pc_inc = 1'b1; pc_load = 1'b1; pc_load_val = 8'h5A;
            exec_done = 1'b1; mem_ack = 1'b1;
            chk("idle_req", mem_req, 0);
            chk("idle_halted", halted, 1);
            chk("idle_pc", pc, m_pc);
            chk("idle_ir", ir, 0);
            step();
        end
        pc_inc = 1'b0; pc_load = 1'b0; exec_done = 1'b0; mem_ack = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] op;
        int dly, inc_at, load_at, done_at;

        //            word     dly inc ld  lval   done       rst pc     h     i
        tbl[0]  = '{16'h1045, 0,  2,  0,  8'h00, 9,         0,  8'h01, 1'b0, 1'b0};
        tbl[1]  = '{16'h2ABC, 5,  0,  0,  8'h00, LONG_DONE, 0,  8'h01, 1'b0, 1'b0};
        tbl[2]  = '{16'h0000, 1,  0,  0,  8'h00, 1,         0,  8'h02, 1'b0, 1'b0};
        tbl[3]  = '{16'h1111, 2,  1,  1,  8'h40, 1,         0,  8'h40, 1'b0, 1'b0};
        tbl[4]  = '{16'h2222, 1,  0,  1,  8'hFF, 2,         0,  8'hFF, 1'b0, 1'b0};
        tbl[5]  = '{16'h1333, 0,  1,  0,  8'h00, 1,         0,  8'h00, 1'b0, 1'b0};
        tbl[6]  = '{16'h2444, 0,  0,  3,  8'h03, 3,         0,  8'h03, 1'b0, 1'b0};
        tbl[7]  = '{16'h0000, 3,  0,  0,  8'h00, 1,         0,  8'h04, 1'b0, 1'b0};
        tbl[8]  = '{16'hF000, 0,  0,  0,  8'h00, 1,         0,  8'h04, 1'b1, 1'b0};
        tbl[9]  = '{16'h0000, 0,  0,  0,  8'h00, 1,         0,  8'h01, 1'b0, 1'b0};
        tbl[10] = '{16'h5000, 2,  0,  0,  8'h00, 1,         0,  8'h01, 1'b1, 1'b1};
        tbl[11] = '{16'h1ABC, 0,  1,  0,  8'h00, 5,         3,  8'h00, 1'b0, 1'b0};
        tbl[12] = '{16'h2055, 0,  1,  0,  8'h00, 1,         0,  8'h01, 1'b0, 1'b0};

        model_reset();
        step();
        step();
        chk("por_pc", pc, 0);
        chk("por_ir", ir, 0);
        chk("por_req", mem_req, 0);
        chk("por_halted", halted, 0);
        chk("por_illegal", illegal, 0);
        chk("por_wdt", wdt_err, 0);
        rst = 1'b0;
        chk("reset_bubble_req", mem_req, 0);
        step();
        chk("first_fetch_req", mem_req, 1);

        for (int i = 0; i < 13; i++) begin
            do_instr(tbl[i].word, tbl[i].dly, tbl[i].inc_at, tbl[i].load_at,
                     tbl[i].lval, tbl[i].done_at, tbl[i].rst_at);
            chk("tbl_pc", pc, tbl[i].exp_pc);
            chk("tbl_halted", halted, tbl[i].exp_h);
            chk("tbl_illegal", illegal, tbl[i].exp_i);
            if (tbl[i].exp_h) begin
                halt_idle();
                async_reset();
            end
        end

        // reset in the middle of a fetch, with a late ack arriving during reset
        chk("pre_rst_req", mem_req, 1);
        chk("pre_rst_pc", pc, 1);
        #2;
        rst = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 16'h5000;
        #1;
        chk("rst_fetch_req", mem_req, 0);
        chk("rst_fetch_pc", pc, 0);
        step();
        step();
        mem_ack = 1'b0;
        rst = 1'b0;
        model_reset();
        do_instr(16'h1046, 0, 1, 0, 8'h00, 2, 0);
        chk("late_ack_illegal", illegal, 0);
        chk("late_ack_pc", pc, 1);

        // randomized instruction stream against the reference model
        for (int k = 0; k < 60; k++) begin
            int r;
            r = $urandom_range(0, 9);
            op = (r < 2) ? 4'h0 : (r < 6) ? 4'h1 : 4'h2;
            dly = $urandom_range(0, 4);
            done_at = $urandom_range(1, 6);
            inc_at = $urandom_range(0, done_at);
            load_at = ($urandom_range(0, 2) != 0) ? 0 : $urandom_range(1, done_at);
            do_instr({op, 12'($urandom)}, dly, inc_at, load_at, 8'($urandom), done_at, 0);
        end
        op = 4'($urandom_range(3, 14));
        do_instr({op, 12'($urandom)}, $urandom_range(0, 4), 0, 0, 8'h00, 1, 0);
        chk("rand_end_illegal", illegal, 1);
        async_reset();

`ifdef WATCHDOG_EN
        do_instr(16'h1777, 0, 0, 0, 8'h00, 0, 0);
        chk("wdt_fire", wdt_err, 1);
        async_reset();
        do_instr(16'h1778, 0, 0, 0, 8'h00, WDT_T, 0);
        chk("wdt_done_wins", wdt_err, 0);
        chk("wdt_done_halted", halted, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
